// File: rtl/operand_fetch.sv
// operand_fetch: decode-to-execute operand fetch with pending-write scoreboard and single-entry output register.
// Define OPFETCH_BYPASS_EN to forward same-cycle writeback data into the fetched operands;
// without it, a same-cycle writeback to a source register stalls the instruction for one cycle.
module operand_fetch #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 5,
    parameter int PAYLOAD_WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_WIDTH-1:0]    in_rs1,
    input  logic [ADDR_WIDTH-1:0]    in_rs2,
    input  logic [ADDR_WIDTH-1:0]    in_rd,
    input  logic                     in_rd_wen,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    output logic                     rf_ren,
    output logic [ADDR_WIDTH-1:0]    rf_raddr1,
    output logic [ADDR_WIDTH-1:0]    rf_raddr2,
    input  logic [DATA_WIDTH-1:0]    rf_rdata1,
    input  logic [DATA_WIDTH-1:0]    rf_rdata2,
    input  logic                     wb_wen,
    input  logic [ADDR_WIDTH-1:0]    wb_waddr,
    input  logic [DATA_WIDTH-1:0]    wb_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_src1,
    output logic [DATA_WIDTH-1:0]    out_src2,
    output logic [ADDR_WIDTH-1:0]    out_rd,
    output logic                     out_rd_wen,
    output logic [PAYLOAD_WIDTH-1:0] out_payload
);
    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [1:0]               cnt_q [NUM_REGS];
    logic [1:0]               cnt_d [NUM_REGS];
    logic                     out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]    out_src1_q, out_src1_d;
    logic [DATA_WIDTH-1:0]    out_src2_q, out_src2_d;
    logic [ADDR_WIDTH-1:0]    out_rd_q, out_rd_d;
    logic                     out_rd_wen_q, out_rd_wen_d;
    logic [PAYLOAD_WIDTH-1:0] out_payload_q, out_payload_d;

    logic                     can_load, t_in, t_out;
    logic                     wb_hit1, wb_hit2, byp1, byp2, haz1, haz2, rd_full;
    logic [DATA_WIDTH-1:0]    src1, src2;

    // Saturating pending-count update: at most one increment and two decrements per cycle.
    function automatic logic [1:0] next_cnt(input logic [1:0] cnt, input logic inc,
                                            input logic dec_wb, input logic dec_fl);
        logic [2:0] up, dn;
        up = {1'b0, cnt} + {2'b0, inc};
        dn = {2'b0, dec_wb} + {2'b0, dec_fl};
        return (up > dn) ? 2'(up - dn) : 2'd0;
    endfunction

    assign rf_ren    = in_valid;
    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;

    // Hazard detection, bypass selection and the accept/transfer handshakes.
    always_comb begin
        can_load = !flush && (!out_valid_q || out_ready);
        wb_hit1  = wb_wen && wb_waddr == in_rs1 && in_rs1 != '0;
        wb_hit2  = wb_wen && wb_waddr == in_rs2 && in_rs2 != '0;
`ifdef OPFETCH_BYPASS_EN
        byp1 = wb_hit1 && cnt_q[in_rs1] == 2'd1;
        byp2 = wb_hit2 && cnt_q[in_rs2] == 2'd1;
        haz1 = in_rs1 != '0 && cnt_q[in_rs1] != 2'd0 && !byp1;
        haz2 = in_rs2 != '0 && cnt_q[in_rs2] != 2'd0 && !byp2;
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
        haz1 = (in_rs1 != '0 && cnt_q[in_rs1] != 2'd0) || wb_hit1;
        haz2 = (in_rs2 != '0 && cnt_q[in_rs2] != 2'd0) || wb_hit2;
`endif
        rd_full  = in_rd_wen && in_rd != '0 && cnt_q[in_rd] == 2'd3;
        in_ready = can_load && !haz1 && !haz2 && !rd_full;
        t_in     = in_valid && in_ready;
        t_out    = out_valid_q && out_ready && !flush;
        src1     = (in_rs1 == '0) ? '0 : byp1 ? wb_wdata : rf_rdata1;
        src2     = (in_rs2 == '0) ? '0 : byp2 ? wb_wdata : rf_rdata2;
    end

    // Next state of the output register: load on accept, drop on transfer or flush, hold otherwise.
    always_comb begin
        out_valid_d   = t_in ? 1'b1 : (t_out || flush) ? 1'b0 : out_valid_q;
        out_src1_d    = t_in ? src1 : out_src1_q;
        out_src2_d    = t_in ? src2 : out_src2_q;
        out_rd_d      = t_in ? in_rd : out_rd_q;
        out_rd_wen_d  = t_in ? in_rd_wen : out_rd_wen_q;
        out_payload_d = t_in ? in_payload : out_payload_q;
    end

    // Scoreboard: count new writers, retire on writeback and on flushed writers; x0 never tracked.
    always_comb begin
        cnt_d[0] = 2'd0;
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = next_cnt(cnt_q[r],
                                t_in && in_rd_wen && in_rd == ADDR_WIDTH'(r),
                                wb_wen && wb_waddr == ADDR_WIDTH'(r),
                                flush && out_valid_q && out_rd_wen_q && out_rd_q == ADDR_WIDTH'(r));
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_src1_q    <= '0;
            out_src2_q    <= '0;
            out_rd_q      <= '0;
            out_rd_wen_q  <= 1'b0;
            out_payload_q <= '0;
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= 2'd0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_src1_q    <= out_src1_d;
            out_src2_q    <= out_src2_d;
            out_rd_q      <= out_rd_d;
            out_rd_wen_q  <= out_rd_wen_d;
            out_payload_q <= out_payload_d;
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    assign out_valid   = out_valid_q;
    assign out_src1    = out_src1_q;
    assign out_src2    = out_src2_q;
    assign out_rd      = out_rd_q;
    assign out_rd_wen  = out_rd_wen_q;
    assign out_payload = out_payload_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: scoreboard bench for operand_fetch with a register-file model (honours OPFETCH_BYPASS_EN).
module tb_operand_fetch;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int PW = 96;
`ifdef OPFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, flush, in_valid, in_ready, in_rd_wen, rf_ren, wb_wen, out_valid, out_ready, out_rd_wen;
    logic [AW-1:0] in_rs1, in_rs2, in_rd, rf_raddr1, rf_raddr2, wb_waddr, out_rd;
    logic [DW-1:0] rf_rdata1, rf_rdata2, wb_wdata, out_src1, out_src2;
    logic [PW-1:0] in_payload, out_payload, bp_pl;
    logic [DW-1:0] regs [32];
    logic [31:0]   pl;

    typedef struct {
        logic [DW-1:0] s1;
        logic [DW-1:0] s2;
        logic [AW-1:0] rd;
        logic          wen;
        logic [PW-1:0] pl;
    } exp_t;
    exp_t sbq[$];
    exp_t e;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    operand_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PAYLOAD_WIDTH(PW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_payload(in_payload),
        .rf_ren(rf_ren), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_src1(out_src1), .out_src2(out_src2),
        .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_payload(out_payload)
    );

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    always @(posedge clk) if (wb_wen) regs[wb_waddr] <= wb_wdata;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_src(input logic [AW-1:0] rs);
        return (rs == '0) ? '0 : (wb_wen && wb_waddr == rs) ? wb_wdata : regs[rs];
    endfunction

    // Pop/compare on output transfer, drop on flush, push expectation on accept.
    always @(negedge clk) begin
        if (!rst_n) sbq.delete();
        else begin
            if (out_valid && flush) begin
                if (sbq.size() != 0) e = sbq.pop_front();
            end else if (out_valid && out_ready) begin
                if (sbq.size() == 0) check_eq("sb_unexpected_out", 1, 0);
                else begin
                    e = sbq.pop_front();
                    check_eq("out_src1", out_src1, e.s1);
                    check_eq("out_src2", out_src2, e.s2);
                    check_eq("out_rd", out_rd, e.rd);
                    check_eq("out_rd_wen", out_rd_wen, e.wen);
                    check_eq("out_payload", out_payload, e.pl);
                end
            end
            if (in_valid && in_ready)
                sbq.push_back('{model_src(in_rs1), model_src(in_rs2), in_rd, in_rd_wen, in_payload});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        wb_wen   = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic offer(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic wen);
        pl         = pl + 1;
        in_valid   = 1'b1;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rd      = rd;
        in_rd_wen  = wen;
        in_payload = {pl, ~pl, pl ^ 32'h5A5A_0000};
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_wen   = 1'b1;
        wb_waddr = a;
        wb_wdata = d;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_wen = 1'b0; in_payload = '0;
        wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0; pl = 0;
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? '0 : 64'h1000 + 64'(i);
        #2;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_src1", out_src1, 0);
        check_eq("rst_src2", out_src2, 0);
        check_eq("rst_rd", {out_rd_wen, out_rd}, 0);
        check_eq("rst_payload", out_payload, 0);
        @(posedge clk);
        cyc();
        rst_n = 1'b1;
        // x0 source/destination, then back-to-back throughput
        offer(0, 0, 0, 1);
        @(negedge clk);
        check_eq("x0_ready", in_ready, 1);
        check_eq("rf_port", {rf_ren, rf_raddr1, rf_raddr2}, {1'b1, 5'd0, 5'd0});
        cyc(); idle();
        @(negedge clk);
        check_eq("x0_valid", out_valid, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(); offer(5'(i + 1), 5'(i + 2), 0, 1);
            @(negedge clk);
            check_eq("b2b_ready", in_ready, 1);
        end
        cyc(); idle();
        // RAW on x5 resolved by writeback
        cyc(); offer(0, 0, 5, 1);
        @(negedge clk); check_eq("raw_wr_ready", in_ready, 1);
        cyc(); offer(5, 3, 0, 0);
        @(negedge clk); check_eq("raw_stall", in_ready, 0);
        cyc(); wb(5, 64'hDEAD);
        @(negedge clk); check_eq("raw_wb_ready", in_ready, BYP);
        cyc(); wb_wen = 1'b0; in_valid = !BYP;
        @(negedge clk); check_eq("raw_after_ready", in_ready, 1);
        cyc(); offer(5, 5, 0, 0);
        @(negedge clk); check_eq("raw_clear_ready", in_ready, 1);
        cyc(); idle();
        // back-pressure
        cyc(); offer(1, 2, 0, 0); bp_pl = in_payload;
        @(negedge clk); check_eq("bp_acc", in_ready, 1);
        cyc(); out_ready = 1'b0; offer(3, 4, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_ready", in_ready, 0);
            check_eq("bp_valid", out_valid, 1);
            check_eq("bp_payload", out_payload, bp_pl);
            check_eq("bp_src1", out_src1, 64'h1001);
            cyc();
        end
        out_ready = 1'b1;
        @(negedge clk); check_eq("bp_release_ready", in_ready, 1);
        cyc(); idle();
        // counter saturation on x7
        for (int i = 0; i < 3; i++) begin
            cyc(); offer(0, 0, 7, 1);
            @(negedge clk); check_eq("sat_wr_ready", in_ready, 1);
        end
        cyc(); offer(0, 0, 7, 1);
        @(negedge clk); check_eq("sat_wr_stall", in_ready, 0);
        cyc(); offer(7, 0, 0, 0);
        @(negedge clk); check_eq("sat_rd_stall", in_ready, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc(); wb(7, 64'h70 + 64'(k));
            @(negedge clk); check_eq("sat_wb_ready", in_ready, BYP && k == 3);
        end
        cyc(); wb_wen = 1'b0; in_valid = !BYP;
        @(negedge clk); check_eq("sat_after_ready", in_ready, 1);
        cyc(); idle();
        // flush with simultaneous writeback to x9
        cyc(); offer(0, 0, 9, 1);
        @(negedge clk); check_eq("fl_w1", in_ready, 1);
        cyc(); offer(0, 0, 9, 1);
        @(negedge clk); check_eq("fl_w2", in_ready, 1);
        cyc(); offer(1, 0, 0, 0); flush = 1'b1; wb(9, 64'h99);
        @(negedge clk); check_eq("fl_ready", in_ready, 0);
        cyc(); idle();
        @(negedge clk); check_eq("fl_valid", out_valid, 0);
        cyc(); offer(9, 0, 0, 0);
        @(negedge clk); check_eq("fl_clear_ready", in_ready, 1);
        cyc(); idle();
        // asynchronous reset mid-operation
        cyc(); offer(0, 0, 11, 1);
        @(negedge clk); check_eq("ar_acc", in_ready, 1);
        cyc(); idle(); out_ready = 1'b0;
        @(negedge clk); check_eq("ar_valid", out_valid, 1);
        cyc();
        #1 rst_n = 1'b0;
        #1;
        check_eq("ar_valid_clr", out_valid, 0);
        check_eq("ar_payload_clr", out_payload, 0);
        cyc(); rst_n = 1'b1; out_ready = 1'b1; offer(11, 0, 11, 1);
        @(negedge clk); check_eq("ar_cnt_clear", in_ready, 1);
        cyc(); idle();
        cyc();
        @(negedge clk); check_eq("sb_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
